// File: rtl/uart_tx_ser_if.sv
// FIFO read-port bundle between the byte FIFO and the UART serialiser.
// master = FIFO side, slave = serialiser side.
interface uart_tx_ser_if;
   logic [7:0] fifo_data_i;
   logic       fifo_empty_i;
   logic       fifo_deq_o;

   modport master (
      output fifo_data_i,
      output fifo_empty_i,
      input  fifo_deq_o
   );

   modport slave (
      input  fifo_data_i,
      input  fifo_empty_i,
      output fifo_deq_o
   );
endinterface

// File: rtl/uart_tx_ser.sv
// UART TX serialiser: drains the byte FIFO, frames start/8 data/stop.
// Define UART_TX_PARITY_EN to insert a parity bit before the stop bit.
module uart_tx_ser #(
   parameter int DIV_W = 16
) (
   input  logic             clk6x,
   input  logic             resetn,
   uart_tx_ser_if.slave     fifo,
   input  logic [DIV_W-1:0] baud_div_i,
   input  logic             cts_n_i,
   input  logic             parity_odd_i,
   output logic             tx_o,
   output logic             busy_o
);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE, START, DATA, STOP
   } state_t;
`endif

   state_t           state;
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] cnt;
   logic [7:0]       shreg;
   logic [2:0]       idx;
   logic             bit_end;
   logic             can_start;

`ifdef UART_TX_PARITY_EN
   logic [7:0]       data_q;
   logic             par_bit;
   assign par_bit = (^data_q) ^ parity_odd_i;
`else
   logic             unused_par;
   assign unused_par = parity_odd_i;
`endif

   assign bit_end   = (cnt == '0);
   assign can_start = !fifo.fifo_empty_i && !cts_n_i;

   // Dequeue on a frame-start decision: from IDLE or the last stop clock.
   assign fifo.fifo_deq_o = resetn && can_start &&
                            ((state == IDLE) ||
                             ((state == STOP) && bit_end));

   // Frame sequencer with registered line and busy outputs.
   always_ff @(posedge clk6x or negedge resetn) begin
      if (!resetn) begin
         state  <= IDLE;
         div_q  <= '0;
         cnt    <= '0;
         shreg  <= '0;
         idx    <= '0;
         tx_o   <= 1'b1;
         busy_o <= 1'b0;
`ifdef UART_TX_PARITY_EN
         data_q <= '0;
`endif
      end else if (fifo.fifo_deq_o) begin
         shreg  <= fifo.fifo_data_i;
         div_q  <= baud_div_i;
         cnt    <= baud_div_i;
         idx    <= '0;
         state  <= START;
         tx_o   <= 1'b0;
         busy_o <= 1'b1;
`ifdef UART_TX_PARITY_EN
         data_q <= fifo.fifo_data_i;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               tx_o   <= 1'b1;
               busy_o <= 1'b0;
            end
            START: begin
               if (bit_end) begin
                  cnt   <= div_q;
                  state <= DATA;
                  tx_o  <= shreg[0];
               end else begin
                  cnt <= cnt - DIV_W'(1);
               end
            end
            DATA: begin
               if (bit_end) begin
                  cnt <= div_q;
                  if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state <= PARITY;
                     tx_o  <= par_bit;
`else
                     state <= STOP;
                     tx_o  <= 1'b1;
`endif
                  end else begin
                     idx   <= idx + 3'd1;
                     shreg <= {1'b0, shreg[7:1]};
                     tx_o  <= shreg[1];
                  end
               end else begin
                  cnt <= cnt - DIV_W'(1);
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  cnt   <= div_q;
                  state <= STOP;
                  tx_o  <= 1'b1;
               end else begin
                  cnt  <= cnt - DIV_W'(1);
                  tx_o <= par_bit;
               end
            end
`endif
            STOP: begin
               if (bit_end) begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
                  tx_o   <= 1'b1;
               end else begin
                  cnt <= cnt - DIV_W'(1);
               end
            end
            default: begin
               state  <= IDLE;
               tx_o   <= 1'b1;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_ser.sv
// Directed bench for uart_tx_ser with a small FIFO model and frame capture.
// Frame length follows UART_TX_PARITY_EN.
module tb_uart_tx_ser;

`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic        clk6x;
   logic        resetn;
   logic [15:0] baud_div;
   logic        cts_n;
   logic        parity_odd;
   logic        tx;
   logic        busy;

   uart_tx_ser_if bus ();

   uart_tx_ser #(.DIV_W(16)) dut (
      .clk6x        (clk6x),
      .resetn       (resetn),
      .fifo         (bus.slave),
      .baud_div_i   (baud_div),
      .cts_n_i      (cts_n),
      .parity_odd_i (parity_odd),
      .tx_o         (tx),
      .busy_o       (busy)
   );

   always #5 clk6x = ~clk6x;

   logic [7:0] mem [16];
   logic [4:0] wr;
   logic [4:0] rd;

   assign bus.fifo_empty_i = (wr == rd);
   assign bus.fifo_data_i  = mem[rd[3:0]];

   always @(posedge clk6x)
      if (bus.fifo_deq_o) rd <= rd + 5'd1;

   int cyc;
   int ndeq;
   int deq_cyc [64];
   int bad_empty;
   int bad_consec;
   logic prev_deq;

   always @(posedge clk6x) begin
      cyc <= cyc + 1;
      if (bus.fifo_deq_o) begin
         if (ndeq < 64) deq_cyc[ndeq] = cyc;
         ndeq = ndeq + 1;
         if (bus.fifo_empty_i) bad_empty = bad_empty + 1;
         if (prev_deq) bad_consec = bad_consec + 1;
      end
      prev_deq = bus.fifo_deq_o;
   end

   int n_cmp;
   int n_err;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr[3:0]] = b;
      wr = wr + 5'd1;
   endtask

   function automatic logic [10:0] exp_frame(input logic [7:0] b,
                                             input logic odd);
      if (NB == 11) return {1'b1, (^b) ^ odd, b, 1'b0};
      else          return {2'b01, b, 1'b0};
   endfunction

   task automatic capture(input int d,
                          output logic [10:0] bits,
                          output int glitch,
                          output int bcnt);
      bits   = '0;
      glitch = 0;
      bcnt   = 0;
      for (int i = 0; i < NB * (d + 1); i++) begin
         @(negedge clk6x);
         if (i % (d + 1) == 0) bits[i / (d + 1)] = tx;
         else if (tx !== bits[i / (d + 1)]) glitch++;
         if (busy) bcnt++;
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      logic [10:0] bits;
      int glitch, bcnt, n0, lo, bz;
      bit done;
      clk6x = 0; resetn = 0; baud_div = 16'd3;
      cts_n = 0; parity_odd = 0;
      wr = '0; rd = '0; cyc = 0; ndeq = 0;
      bad_empty = 0; bad_consec = 0; prev_deq = 0;
      n_cmp = 0; n_err = 0;

      // reset values
      #12;
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_deq", bus.fifo_deq_o, 0);
      @(negedge clk6x); resetn = 1;
      repeat (3) @(negedge clk6x);

      // single byte 8N1, D=3
      baud_div = 16'd3; n0 = ndeq;
      push(8'h55); #1;
      chk("t1_deq", bus.fifo_deq_o, 1);
      capture(3, bits, glitch, bcnt);
      chk("t1_frame", bits, exp_frame(8'h55, 0));
      chk("t1_glitch", glitch, 0);
      chk("t1_busy", bcnt, NB * 4);
      chk("t1_ndeq", ndeq - n0, 1);
      @(negedge clk6x);
      chk("t1_idle_busy", busy, 0);
      chk("t1_idle_tx", tx, 1);

      // back-to-back, D=1
      repeat (2) @(negedge clk6x);
      baud_div = 16'd1; n0 = ndeq;
      push(8'h12); push(8'h34); push(8'h56); push(8'h78);
      bz = 0;
      capture(1, bits, glitch, bcnt); bz += bcnt;
      chk("b2b_f0", bits, exp_frame(8'h12, 0));
      capture(1, bits, glitch, bcnt); bz += bcnt;
      chk("b2b_f1", bits, exp_frame(8'h34, 0));
      capture(1, bits, glitch, bcnt); bz += bcnt;
      chk("b2b_f2", bits, exp_frame(8'h56, 0));
      capture(1, bits, glitch, bcnt); bz += bcnt;
      chk("b2b_f3", bits, exp_frame(8'h78, 0));
      chk("b2b_busy", bz, 4 * NB * 2);
      chk("b2b_ndeq", ndeq - n0, 4);
      chk("b2b_gap0", deq_cyc[n0 + 1] - deq_cyc[n0], NB * 2);
      chk("b2b_gap1", deq_cyc[n0 + 2] - deq_cyc[n0 + 1], NB * 2);
      chk("b2b_gap2", deq_cyc[n0 + 3] - deq_cyc[n0 + 2], NB * 2);
      @(negedge clk6x);
      chk("b2b_empty", bus.fifo_empty_i, 1);
      chk("b2b_end_busy", busy, 0);

      // flow control
      cts_n = 1; n0 = ndeq;
      push(8'hA5); push(8'hC3);
      lo = 0;
      repeat (10) begin
         @(negedge clk6x);
         if (tx !== 1'b1) lo++;
      end
      chk("fc_hold_deq", ndeq - n0, 0);
      chk("fc_hold_tx", lo, 0);
      cts_n = 0; #1;
      chk("fc_go_deq", bus.fifo_deq_o, 1);
      fork
         begin
            repeat (5) @(negedge clk6x);
            cts_n = 1;
         end
      join_none
      capture(1, bits, glitch, bcnt);
      chk("fc_frame", bits, exp_frame(8'hA5, 0));
      repeat (5) @(negedge clk6x);
      chk("fc_ndeq", ndeq - n0, 1);
      chk("fc_pending", bus.fifo_empty_i, 0);
      chk("fc_busy", busy, 0);
      cts_n = 0; #1;
      chk("fc_drain_deq", bus.fifo_deq_o, 1);
      capture(1, bits, glitch, bcnt);
      chk("fc_frame2", bits, exp_frame(8'hC3, 0));
      @(negedge clk6x);

`ifdef UART_TX_PARITY_EN
      // parity, D=0
      baud_div = 16'd0; parity_odd = 0;
      push(8'h07);
      capture(0, bits, glitch, bcnt);
      chk("par_even", bits, {1'b1, 1'b1, 8'h07, 1'b0});
      chk("par_even_len", bcnt, 11);
      @(negedge clk6x);
      parity_odd = 1;
      push(8'h07);
      capture(0, bits, glitch, bcnt);
      chk("par_odd", bits, {1'b1, 1'b0, 8'h07, 1'b0});
      @(negedge clk6x);
      parity_odd = 0;
`endif

      // D=0 with 0xFF
      baud_div = 16'd0;
      push(8'hFF);
      capture(0, bits, glitch, bcnt);
      chk("d0_frame", bits, exp_frame(8'hFF, 0));
      chk("d0_len", bcnt, NB);
      @(negedge clk6x);
      chk("d0_end_busy", busy, 0);

      // reset mid-frame
      baud_div = 16'd3;
      push(8'hF0);
      repeat (8) @(negedge clk6x);
      chk("rmf_pre_tx", tx, 0);
      resetn = 0; #1;
      chk("rmf_tx", tx, 1);
      chk("rmf_busy", busy, 0);
      @(negedge clk6x); resetn = 1; n0 = ndeq;
      lo = 0;
      repeat (10) begin
         @(negedge clk6x);
         if (tx !== 1'b1 || busy !== 1'b0) lo++;
      end
      chk("rmf_ndeq", ndeq - n0, 0);
      chk("rmf_idle", lo, 0);

      // D=0xFFFF: start bit length
      baud_div = 16'hFFFF;
      push(8'h01); #1;
      chk("dmax_deq", bus.fifo_deq_o, 1);
      lo = 0; done = 0;
      for (int i = 0; i < 70000 && !done; i++) begin
         @(negedge clk6x);
         if (tx === 1'b0) lo++;
         else done = 1;
      end
      chk("dmax_start", lo, 65536);
      resetn = 0;
      @(negedge clk6x); resetn = 1;

      chk("deq_when_empty", bad_empty, 0);
      chk("deq_consec", bad_consec, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx_ser.md
# uart_tx_ser

Serial transmitter that drains the NORA byte FIFO read port and shifts each byte out on a UART TX line: start bit, 8 data bits LSB-first, optional parity, 1 stop bit. It sits directly downstream of a `fifo` instance (BITWIDTH=8) and connects to its `rport_o`, `rdeq_i` and `empty_o`. Bit timing comes from a programmable clock divider. Hardware flow control (CTS) gates the start of each frame.

## Interface
- `DIV_W`, default 16: width of the bit-period divider.
- `clk6x`  in  1  system clock, 48 MHz.
- `resetn`  in  1  asynchronous, active-low reset.
- `fifo_data_i`  in  8  FIFO `rport_o`; valid whenever `fifo_empty_i`=0.
- `fifo_empty_i`  in  1  FIFO `empty_o`.
- `fifo_deq_o`  out  1  to FIFO `rdeq_i`; one-cycle dequeue strobe.
- `baud_div_i`  in  DIV_W  clocks per bit minus 1; latched at frame start.
- `cts_n_i`  in  1  clear-to-send, active low; 1 blocks new frames.
- `parity_odd_i`  in  1  parity sense, 1=odd and 0=even; used only with the parity feature.
- `tx_o`  out  1  serial line; idles high.
- `busy_o`  out  1  frame in progress, from start bit through the end of the stop bit.

## Operation
- FSM states: IDLE, START, DATA, PARITY (parity build only), STOP.
- A frame may begin when `fifo_empty_i`=0 and `cts_n_i`=0.
- Frame start from IDLE:
  - `fifo_deq_o`=1 combinationally in that cycle.
  - On the same edge: `fifo_data_i` → shift register, `baud_div_i` → `div_q`, FSM → START.
- Bit counter: down-counter reloads `div_q` at each bit start. A bit ends on the cycle the counter = 0, so every bit is exactly `div_q`+1 clocks. `baud_div_i`=0 gives 1 clock per bit.
- START: `tx_o`=0.
- DATA: `tx_o`=shreg[0]; shift right at each bit end. A 3-bit index goes 0..7; at index 7 the FSM goes to PARITY or STOP.
- PARITY: `tx_o` = ^data XOR `parity_odd_i`, using the latched byte.
- STOP: `tx_o`=1.
- Last clock of STOP, back-to-back:
  - If a new frame may begin, assert `fifo_deq_o`, latch data and divider, and go straight to START. There is no idle gap.
  - Otherwise go to IDLE.
- `cts_n_i` is sampled only at frame-start decisions. Deasserting it mid-frame never truncates the frame.
- `fifo_deq_o` is never asserted when `fifo_empty_i`=1, and is never high on two consecutive cycles.
- Changes to `baud_div_i` or `parity_odd_i` mid-frame: the divider takes effect at the next frame start. Parity uses the live `parity_odd_i` value during PARITY, so it must be held stable by software.

## Timing
- Reset values, asynchronous: `tx_o`=1, `busy_o`=0, `fifo_deq_o`=0, FSM=IDLE, counters 0.
- Reset mid-frame: `tx_o` returns high immediately. The dequeued byte is discarded. Restart is allowed from the first clock after release.
- `tx_o` and `busy_o` are registered. `fifo_deq_o` is Mealy (state + `fifo_empty_i` + `cts_n_i` + counter).
- Latency: start bit drives `tx_o` on the edge that samples `fifo_deq_o`=1, i.e. one clock after the IDLE decision cycle.
- Frame length is 10·(D+1) clocks, or 11·(D+1) with parity, where D=latched divider. Back-to-back frames have period exactly equal to the frame length.
- `busy_o`=1 from the first start-bit clock through the last stop-bit clock. It stays high continuously across back-to-back frames.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state compiled in, with one parity bit between D7 and the stop bit; frame is 11 bits.
- Undefined: PARITY state and logic removed; `parity_odd_i` ignored (port kept for pin compatibility); 8N1, 10 bits.

## Test plan
- Single byte, 8N1: D=3, enqueue 0x55, cts_n=0.
  - `fifo_deq_o` pulses 1 clock.
  - `tx_o` = 0,1,0,1,0,1,0,1,0,1, each 4 clocks (40 total).
  - `busy_o` high 40 clocks.
- Back-to-back: D=1, enqueue 0x12,0x34,0x56,0x78.
  - 4 deq pulses spaced exactly 20 clocks.
  - Decoded bytes in order; `busy_o` never drops; FIFO empty after the last deq.
- Flow control: cts_n=1, enqueue 0xA5.
  - No deq, `tx_o` stays 1.
  - Drop cts_n to 0: frame starts next cycle.
  - Raise cts_n mid-frame: frame completes, no further deq.
- Parity (macro on), D=0, byte 0x07:
  - Even parity → parity bit 1; odd → 0.
  - Frame is 11 clocks.
- Reset mid-frame: assert resetn=0 during DATA of 0xF0.
  - `tx_o`=1 and `busy_o`=0 immediately.
  - After release with FIFO empty: no deq and line idle.
- Divider edge: D=0 with 0xFF → 10-clock frame. D=0xFFFF → start bit lasts 65536 clocks.
